// File: rtl/uart_rx32_deframer.sv
// Header-framed 32-bit word deframer for a uart_rx byte stream: hunts for HEADER_BYTE, then packs 4 payload bytes MSB first.
// Optional inter-byte timeout abort is built only when RX32_TIMEOUT_EN is defined.
module uart_rx32_deframer #(
    parameter logic [7:0] HEADER_BYTE   = 8'h49,
    parameter int         PAYLOAD_BYTES = 4,
    parameter int         TIMEOUT_CLKS  = 12500,
    parameter int         TO_WIDTH      = 16
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_rxdv,
    input  logic [7:0]  i_rxbyte,
    output logic        o_dataval,
    output logic [31:0] o_dataout,
    output logic        o_frame_err,
    output logic [7:0]  o_err_count,
    output logic        o_busy
);

    localparam int CNT_W = $clog2(PAYLOAD_BYTES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAYLOAD_BYTES - 1);

    typedef enum logic [0:0] {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [23:0]      shift_r;
    logic [23:0]      shift_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             hdr_hit_s;
    logic             done_s;
    logic             timeout_s;

    assign hdr_hit_s = i_rxdv && (i_rxbyte == HEADER_BYTE);
    assign done_s    = (state_r == COLLECT) && i_rxdv && (cnt_r == LAST_IDX);

`ifdef RX32_TIMEOUT_EN
    logic [TO_WIDTH-1:0] to_r;
    logic [TO_WIDTH-1:0] to_nxt_s;
    logic                frame_err_r;
    logic [7:0]          err_count_r;

    // A strobe landing in the expiry cycle wins, so expiry needs a quiet TIMEOUT_CLKS-th cycle.
    assign timeout_s = (state_r == COLLECT) && !i_rxdv &&
                       (to_r == TO_WIDTH'(TIMEOUT_CLKS - 1));

    // Timer next value: idle outside COLLECT, restarts on each byte.
    always_comb begin
        to_nxt_s = to_r;
        if ((state_r != COLLECT) || i_rxdv || timeout_s) begin
            to_nxt_s = {TO_WIDTH{1'b0}};
        end else begin
            to_nxt_s = to_r + TO_WIDTH'(1);
        end
    end

    // Timer, abort strobe and saturating abort counter.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            to_r        <= {TO_WIDTH{1'b0}};
            frame_err_r <= 1'b0;
            err_count_r <= 8'h00;
        end else begin
            to_r        <= to_nxt_s;
            frame_err_r <= timeout_s;
            if (timeout_s && (err_count_r != 8'hFF)) begin
                err_count_r <= err_count_r + 8'h01;
            end
        end
    end

    assign o_frame_err = frame_err_r;
    assign o_err_count = err_count_r;
`else
    assign timeout_s   = 1'b0;
    assign o_frame_err = 1'b0;
    assign o_err_count = 8'h00;
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_r <= HUNT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: a 0x49 inside COLLECT is ordinary payload.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            HUNT: begin
                if (hdr_hit_s) begin
                    state_nxt_s = COLLECT;
                end else begin
                    state_nxt_s = HUNT;
                end
            end
            COLLECT: begin
                if (done_s || timeout_s) begin
                    state_nxt_s = HUNT;
                end else begin
                    state_nxt_s = COLLECT;
                end
            end
            default: state_nxt_s = HUNT;
        endcase
    end

    // Payload shift register and byte counter next values.
    always_comb begin
        shift_nxt_s = shift_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            HUNT: begin
                if (hdr_hit_s) begin
                    shift_nxt_s = 24'h000000;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    shift_nxt_s = shift_r;
                    cnt_nxt_s   = cnt_r;
                end
            end
            COLLECT: begin
                if (done_s || timeout_s) begin
                    shift_nxt_s = 24'h000000;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else if (i_rxdv) begin
                    shift_nxt_s = {shift_r[15:0], i_rxbyte};
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                end else begin
                    shift_nxt_s = shift_r;
                    cnt_nxt_s   = cnt_r;
                end
            end
            default: begin
                shift_nxt_s = 24'h000000;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Datapath and registered outputs; o_dataout only moves on completion.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            shift_r   <= 24'h000000;
            cnt_r     <= {CNT_W{1'b0}};
            o_dataval <= 1'b0;
            o_dataout <= 32'h00000000;
            o_busy    <= 1'b0;
        end else begin
            shift_r   <= shift_nxt_s;
            cnt_r     <= cnt_nxt_s;
            o_dataval <= done_s;
            o_busy    <= (state_nxt_s == COLLECT);
            if (done_s) begin
                o_dataout <= {shift_r, i_rxbyte};
            end
        end
    end

endmodule

// File: tb/tb_uart_rx32_deframer.sv
// Randomised self-checking bench for uart_rx32_deframer against a byte-queue frame model.
// Timeout scenarios are exercised only when RX32_TIMEOUT_EN is defined.
module tb_uart_rx32_deframer;

    localparam int TO = 100;
`ifdef RX32_TIMEOUT_EN
    localparam int GAP1 = 60;
`else
    localparam int GAP1 = 6250;
`endif

    logic        clk;
    logic        rstn;
    logic        rxdv;
    logic [7:0]  rxbyte;
    logic        dataval;
    logic [31:0] dataout;
    logic        frame_err;
    logic [7:0]  err_count;
    logic        busy;

    uart_rx32_deframer #(.TIMEOUT_CLKS(TO)) dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_rxdv     (rxdv),
        .i_rxbyte   (rxbyte),
        .o_dataval  (dataval),
        .o_dataout  (dataout),
        .o_frame_err(frame_err),
        .o_err_count(err_count),
        .o_busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: frame collection as a queue of payload bytes
    bit         m_collecting;
    byte        m_q[$];
    int         m_idle;
    bit [31:0]  m_word;
    bit         m_val;
    bit         m_err;
    int         m_errcnt;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int val_pulses = 0;
    int err_pulses = 0;
    int last_val_cyc = 0;
    int prev_val_cyc = 0;
    bit [31:0] words[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_collecting = 1'b0;
        m_q.delete();
        m_idle   = 0;
        m_word   = 32'h0;
        m_val    = 1'b0;
        m_err    = 1'b0;
        m_errcnt = 0;
    endtask

    task automatic compare_all();
        check("dataval",   {31'h0, dataval},   {31'h0, m_val});
        check("dataout",   dataout,            m_word);
        check("frame_err", {31'h0, frame_err}, {31'h0, m_err});
        check("err_count", {24'h0, err_count}, m_errcnt);
        check("busy",      {31'h0, busy},      {31'h0, m_collecting});
    endtask

    // One clock: drive inputs, advance model, then compare after the edge
    task automatic step(input logic dv, input logic [7:0] b);
        rxdv   = dv;
        rxbyte = b;
        m_val  = 1'b0;
        m_err  = 1'b0;
        if (!m_collecting) begin
            if (dv && b == 8'h49) begin
                m_collecting = 1'b1;
                m_q.delete();
                m_idle = 0;
            end
        end else if (dv) begin
            m_q.push_back(b);
            m_idle = 0;
            if (m_q.size() == 4) begin
                m_word = {m_q[0], m_q[1], m_q[2], m_q[3]};
                m_val  = 1'b1;
                m_collecting = 1'b0;
            end
        end else begin
`ifdef RX32_TIMEOUT_EN
            m_idle++;
            if (m_idle == TO) begin
                m_err = 1'b1;
                m_collecting = 1'b0;
                if (m_errcnt < 255) m_errcnt++;
            end
`endif
        end
        @(posedge clk);
        #1;
        rxdv = 1'b0;
        cyc++;
        compare_all();
        if (dataval) begin
            val_pulses++;
            prev_val_cyc = last_val_cyc;
            last_val_cyc = cyc;
            words.push_back(dataout);
        end
        if (frame_err) err_pulses++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom));
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        model_reset();
        #3;
        check("rst_busy",    {31'h0, busy},      32'h0);
        check("rst_dataout", dataout,            32'h0);
        check("rst_dataval", {31'h0, dataval},   32'h0);
        check("rst_err",     {31'h0, frame_err}, 32'h0);
        check("rst_errcnt",  {24'h0, err_count}, 32'h0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(2);
    endtask

    initial begin
        int p0;
        int e0;
        logic [7:0] t1[4];
        rxdv   = 1'b0;
        rxbyte = 8'h00;
        rstn   = 1'b1;
        model_reset();
        #2;
        do_reset();

        // 1: spaced frame
        t1[0] = 8'h12; t1[1] = 8'h34; t1[2] = 8'h56; t1[3] = 8'h78;
        send(8'h49);
        for (int i = 0; i < 4; i++) begin
            idle(GAP1 - 1);
            send(t1[i]);
        end
        check("t1_val",  {31'h0, dataval}, 32'h1);
        check("t1_word", dataout, 32'h12345678);
        idle(3);

        // 2: junk before header, 0x49 as payload
        p0 = val_pulses;
        send(8'h00); idle(2); send(8'hFF); idle(2); send(8'h49); idle(1);
        send(8'h49); send(8'h00); idle(3); send(8'h00); send(8'h49);
        idle(4);
        check("t2_pulses", val_pulses - p0, 1);
        check("t2_word", dataout, 32'h49000049);

        // 3: back-to-back frames
        p0 = val_pulses;
        send(8'h49); send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        send(8'h49); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        idle(3);
        check("t3_pulses", val_pulses - p0, 2);
        check("t3_spacing", last_val_cyc - prev_val_cyc, 5);
        check("t3_word0", words[words.size() - 2], 32'hAABBCCDD);
        check("t3_word1", words[words.size() - 1], 32'h01020304);

        // 5: reset mid-frame
        send(8'h49); send(8'h11); send(8'h22);
        do_reset();
        check("t5_busy", {31'h0, busy}, 32'h0);
        check("t5_dataout", dataout, 32'h0);
        send(8'h49); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        check("t5_word", dataout, 32'h01020304);
        idle(2);

`ifdef RX32_TIMEOUT_EN
        // 4: timeout abort, then expiry-cycle byte wins
        do_reset();
        e0 = err_pulses;
        send(8'h49); send(8'h11); send(8'h22);
        idle(150);
        send(8'h49); send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        idle(2);
        check("t4_errpulses", err_pulses - e0, 1);
        check("t4_errcount", {24'h0, err_count}, 32'd1);
        check("t4_word", dataout, 32'hAABBCCDD);
        e0 = err_pulses;
        send(8'h49); send(8'h11);
        idle(TO - 1);
        send(8'h22); send(8'h33); send(8'h44);
        idle(2);
        check("t4b_errpulses", err_pulses - e0, 0);
        check("t4b_word", dataout, 32'h11223344);

        // 6: counter saturation
        e0 = err_pulses;
        for (int i = 0; i < 300; i++) begin
            send(8'h49);
            idle(TO + 2);
        end
        check("t6_errpulses", err_pulses - e0, 300);
        check("t6_errcount", {24'h0, err_count}, 32'd255);
`endif

        // Random traffic with frequent headers and occasional long gaps
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 60) == 0) begin
                idle($urandom_range(90, 130));
            end else begin
                step($urandom_range(0, 2) == 0,
                     ($urandom_range(0, 3) == 0) ? 8'h49 : 8'($urandom));
            end
        end
`ifndef RX32_TIMEOUT_EN
        check("nomacro_errcount", {24'h0, err_count}, 32'h0);
        check("nomacro_errpulses", err_pulses, 0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
